// File: rtl/z16_dmem_arbiter_if.sv
// Bus bundle between the Z16 data-memory arbiter, its two requesters and the memory.
// Handshake: req is valid and gnt is ready; a transfer happens in any cycle with req & gnt,
// and a requester holds req/we/addr/wdata stable until it sees gnt.
interface z16_dmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req0, i_req1;
  logic              i_we0, i_we1;
  logic [ADDR_W-1:0] i_addr0, i_addr1;
  logic [DATA_W-1:0] i_wdata0, i_wdata1;
  logic              o_gnt0, o_gnt1;
  logic              o_rvalid0, o_rvalid1;
  logic [DATA_W-1:0] o_rdata0, o_rdata1;
  logic              o_cpu_stall;
  logic              o_mem_en;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    input  o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1, o_cpu_stall,
           o_mem_en, o_mem_wen, o_mem_addr, o_mem_wdata
  );

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1, i_wdata0, i_wdata1, i_mem_rdata,
    output o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_rdata0, o_rdata1, o_cpu_stall,
           o_mem_en, o_mem_wen, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/z16_dmem_arbiter.sv
// Two-port arbiter for the Z16 single-port data memory: same-cycle grant, one command per
// cycle, one-cycle read return routed to the port that issued the read.
module z16_dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_BURST  = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  z16_dmem_arbiter_if.slave bus
);
  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

  logic       last_q, last_d;
  logic [3:0] burst_q, burst_d;
  logic [1:0] rd_own_q, rd_own_d;
  logic       gnt0, gnt1;
  logic       tie_pick1;

  // Tie-break: once the last owner has used its burst allowance the other port wins,
  // even if the counter ran past the limit while it was the only requester.
  always_comb begin
    tie_pick1 = ~last_q;
    if (burst_q < BURST_LIM && FIXED_PRIO != 0) begin
      tie_pick1 = 1'b0;
    end
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!i_rst) begin
      if (bus.i_req0 && bus.i_req1) begin
        gnt1 = tie_pick1;
        gnt0 = ~tie_pick1;
      end else begin
        gnt0 = bus.i_req0;
        gnt1 = bus.i_req1;
      end
    end
  end

  always_comb begin
    bus.o_mem_en    = gnt0 | gnt1;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_addr  = '0;
    bus.o_mem_wdata = '0;
    if (gnt0) begin
      bus.o_mem_wen   = bus.i_we0;
      bus.o_mem_addr  = bus.i_addr0;
      bus.o_mem_wdata = bus.i_wdata0;
    end else if (gnt1) begin
      bus.o_mem_wen   = bus.i_we1;
      bus.o_mem_addr  = bus.i_addr1;
      bus.o_mem_wdata = bus.i_wdata1;
    end
  end

  always_comb begin
    last_d   = last_q;
    burst_d  = 4'd0;
    rd_own_d = {gnt1 & ~bus.i_we1, gnt0 & ~bus.i_we0};
    if (gnt0 || gnt1) begin
      if (gnt1 == last_q) begin
        burst_d = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;
      end else begin
        last_d  = gnt1;
        burst_d = 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q   <= 1'b1;
      burst_q  <= 4'd0;
      rd_own_q <= 2'b00;
    end else begin
      last_q   <= last_d;
      burst_q  <= burst_d;
      rd_own_q <= rd_own_d;
    end
  end

  // Gating with reset drops a read return that was already in flight when reset arrived.
  assign bus.o_gnt0      = gnt0;
  assign bus.o_gnt1      = gnt1;
  assign bus.o_rvalid0   = rd_own_q[0] & ~i_rst;
  assign bus.o_rvalid1   = rd_own_q[1] & ~i_rst;
  assign bus.o_rdata0    = bus.i_mem_rdata;
  assign bus.o_rdata1    = bus.i_mem_rdata;
  assign bus.o_cpu_stall = bus.i_req0 & ~gnt0;
endmodule

// File: tb/tb_z16_dmem_arbiter.sv
// Bench for z16_dmem_arbiter: a round-robin instance (k=0) and a fixed-priority instance
// (k=1), each with its own memory, checked every cycle against a behavioural model.
module tb_z16_dmem_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // stimulus per instance k, port n
  logic [1:0]  st_req [2];
  logic [1:0]  st_we  [2];
  logic [15:0] st_addr  [2][2];
  logic [15:0] st_wdata [2][2];

  // observed DUT outputs
  logic [1:0]  ob_gnt    [2];
  logic [1:0]  ob_rvalid [2];
  logic [31:0] ob_rdata  [2];
  logic        ob_stall  [2];
  logic        ob_en     [2];
  logic        ob_wen    [2];
  logic [15:0] ob_addr   [2];
  logic [15:0] ob_wdata  [2];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [15:0] mem_init(input int idx);
    logic [15:0] a;
    a = 16'(idx * 2);
    return a ^ 16'hA5A5;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_dut
    z16_dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [15:0] mem [256];
    logic [15:0] mem_rd;

    z16_dmem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(k), .MAX_BURST(MAXB)
    ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
    );

    assign bus.i_req0      = st_req[k][0];
    assign bus.i_req1      = st_req[k][1];
    assign bus.i_we0       = st_we[k][0];
    assign bus.i_we1       = st_we[k][1];
    assign bus.i_addr0     = st_addr[k][0];
    assign bus.i_addr1     = st_addr[k][1];
    assign bus.i_wdata0    = st_wdata[k][0];
    assign bus.i_wdata1    = st_wdata[k][1];
    assign bus.i_mem_rdata = mem_rd;

    assign ob_gnt[k]    = {bus.o_gnt1, bus.o_gnt0};
    assign ob_rvalid[k] = {bus.o_rvalid1, bus.o_rvalid0};
    assign ob_rdata[k]  = {bus.o_rdata1, bus.o_rdata0};
    assign ob_stall[k]  = bus.o_cpu_stall;
    assign ob_en[k]     = bus.o_mem_en;
    assign ob_wen[k]    = bus.o_mem_wen;
    assign ob_addr[k]   = bus.o_mem_addr;
    assign ob_wdata[k]  = bus.o_mem_wdata;

    // single-port memory with one-cycle read latency, reloaded with a known pattern on reset
    always @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
      end else if (bus.o_mem_en) begin
        if (bus.o_mem_wen) mem[bus.o_mem_addr[8:1]] <= bus.o_mem_wdata;
        else               mem_rd <= mem[bus.o_mem_addr[8:1]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
  endtask

  // behavioural model state
  int          m_last  [2] = '{1, 1};
  int          m_burst [2] = '{0, 0};
  int          m_pend  [2] = '{-1, -1};
  logic [15:0] m_pdata [2];
  logic [15:0] ref_mem [2][256];
  int          m_wait  [2][2];
  logic [1:0]  m_gnt   [2] = '{2'b00, 2'b00};

  task automatic model_step(input int k);
    int          win;
    logic [1:0]  eg, erv;
    logic        ewen;
    logic [15:0] eaddr, ewd, got_rd;
    int          idx;
    win = -1;
    if (!rst) begin
      if (st_req[k] == 2'b11) begin
        if (m_burst[k] >= MAXB) win = 1 - m_last[k];
        else if (k == 1)        win = 0;
        else                    win = 1 - m_last[k];
      end else if (st_req[k][0]) win = 0;
      else if (st_req[k][1])     win = 1;
    end
    eg = 2'b00; ewen = 1'b0; eaddr = 16'h0; ewd = 16'h0;
    if (win >= 0) begin
      eg[win] = 1'b1;
      ewen    = st_we[k][win];
      eaddr   = st_addr[k][win];
      ewd     = st_wdata[k][win];
    end
    erv = 2'b00;
    if (!rst && m_pend[k] >= 0) erv[m_pend[k]] = 1'b1;

    chk($sformatf("k%0d_gnt", k), 32'(ob_gnt[k]), 32'(eg));
    chk($sformatf("k%0d_stall", k), 32'(ob_stall[k]), 32'(st_req[k][0] & ~eg[0]));
    chk($sformatf("k%0d_mem_en", k), 32'(ob_en[k]), 32'(win >= 0));
    chk($sformatf("k%0d_mem_wen", k), 32'(ob_wen[k]), 32'(ewen));
    chk($sformatf("k%0d_mem_addr", k), 32'(ob_addr[k]), 32'(eaddr));
    chk($sformatf("k%0d_mem_wdata", k), 32'(ob_wdata[k]), 32'(ewd));
    chk($sformatf("k%0d_rvalid", k), 32'(ob_rvalid[k]), 32'(erv));
    if (erv != 2'b00) begin
      got_rd = (m_pend[k] == 1) ? ob_rdata[k][31:16] : ob_rdata[k][15:0];
      chk($sformatf("k%0d_rdata%0d", k, m_pend[k]), 32'(got_rd), 32'(m_pdata[k]));
    end
    chk($sformatf("k%0d_one_gnt", k), 32'(ob_gnt[k] == 2'b11), 32'(0));

    // starvation measured on the DUT's own grants
    for (int n = 0; n < 2; n++) begin
      if (!rst && st_req[k][n] && !ob_gnt[k][n]) m_wait[k][n]++;
      else m_wait[k][n] = 0;
      if (m_wait[k][n] > 0)
        chk($sformatf("k%0d_starve%0d", k, n), 32'(m_wait[k][n] > MAXB), 32'(0));
    end

    m_gnt[k] = eg;
    if (rst) begin
      m_last[k] = 1; m_burst[k] = 0; m_pend[k] = -1;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = mem_init(i);
    end else if (win >= 0) begin
      if (win == m_last[k]) m_burst[k] = (m_burst[k] >= 15) ? 15 : m_burst[k] + 1;
      else begin m_last[k] = win; m_burst[k] = 1; end
      idx = int'(eaddr[8:1]);
      if (ewen) begin ref_mem[k][idx] = ewd; m_pend[k] = -1; end
      else begin m_pend[k] = win; m_pdata[k] = ref_mem[k][idx]; end
    end else begin
      m_burst[k] = 0; m_pend[k] = -1;
    end
  endtask

  // compare process
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      st_req[k] = 2'b00; st_we[k] = 2'b00;
      for (int n = 0; n < 2; n++) begin st_addr[k][n] = 16'h0; st_wdata[k][n] = 16'h0; end
    end
  endtask

  task automatic rand_port(input int k, input int n);
    st_req[k][n]   = ($urandom_range(0, 99) < 70);
    st_we[k][n]    = 1'($urandom_range(0, 1));
    st_addr[k][n]  = 16'($urandom_range(0, 31) * 2);
    st_wdata[k][n] = 16'($urandom);
  endtask

  logic [9:0] fp_pat;

  initial begin
    fp_pat = 10'b10_0001_0000;
    idle_all();
    rst = 1'b1;
    st_req[0] = 2'b11;
    st_req[1] = 2'b11;
    @(negedge clk);
    chk("rst_gnt", 32'(ob_gnt[0]), 32'(0));
    chk("rst_stall", 32'(ob_stall[0]), 32'(1));
    chk("rst_mem_en", 32'(ob_en[0]), 32'(0));
    chk("rst_rvalid", 32'(ob_rvalid[0]), 32'(0));

    // lone port-0 read
    tick();
    rst = 1'b0;
    idle_all();
    st_req[0] = 2'b01; st_addr[0][0] = 16'h0010;
    @(negedge clk);
    chk("t1_gnt", 32'(ob_gnt[0]), 32'(2'b01));
    chk("t1_addr", 32'(ob_addr[0]), 32'h0010);
    chk("t1_wen", 32'(ob_wen[0]), 32'(0));
    tick();
    st_req[0] = 2'b00;
    @(negedge clk);
    chk("t1_rvalid", 32'(ob_rvalid[0]), 32'(2'b01));
    chk("t1_rdata0", 32'(ob_rdata[0][15:0]), 32'hA5B5);

    // both ports requesting continuously on both instances
    tick();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      st_req[k] = 2'b11;
      st_addr[k][0] = 16'h0004; st_addr[k][1] = 16'h0008;
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("t2_rr_gnt%0d", i), 32'(ob_gnt[0]), (i % 2 == 1) ? 32'(2'b10) : 32'(2'b01));
      chk($sformatf("t2_rr_stall%0d", i), 32'(ob_stall[0]), 32'(i % 2));
      chk($sformatf("t3_fp_gnt%0d", i), 32'(ob_gnt[1]), fp_pat[i] ? 32'(2'b10) : 32'(2'b01));
      tick();
    end

    // port-1 write then port-0 read of the same word
    idle_all();
    st_req[0] = 2'b10; st_we[0] = 2'b10;
    st_addr[0][1] = 16'h0100; st_wdata[0][1] = 16'hBEEF;
    @(negedge clk);
    chk("t4_wgnt", 32'(ob_gnt[0]), 32'(2'b10));
    chk("t4_wen", 32'(ob_wen[0]), 32'(1));
    chk("t4_wdata", 32'(ob_wdata[0]), 32'hBEEF);
    tick();
    st_req[0] = 2'b01; st_we[0] = 2'b00; st_addr[0][0] = 16'h0100;
    @(negedge clk);
    chk("t4_no_rv_after_wr", 32'(ob_rvalid[0]), 32'(0));
    chk("t4_rgnt", 32'(ob_gnt[0]), 32'(2'b01));
    tick();
    st_req[0] = 2'b00;
    @(negedge clk);
    chk("t4_rvalid", 32'(ob_rvalid[0]), 32'(2'b01));
    chk("t4_rdata0", 32'(ob_rdata[0][15:0]), 32'hBEEF);

    // reset right after a granted read
    tick();
    st_req[0] = 2'b01; st_addr[0][0] = 16'h0010;
    @(negedge clk);
    chk("t5_gnt", 32'(ob_gnt[0]), 32'(2'b01));
    tick();
    rst = 1'b1; st_req[0] = 2'b00;
    @(negedge clk);
    chk("t5_rv_n1", 32'(ob_rvalid[0]), 32'(0));
    tick();
    rst = 1'b0; st_req[0] = 2'b11;
    @(negedge clk);
    chk("t5_rv_n2", 32'(ob_rvalid[0]), 32'(0));
    chk("t5_first_tie", 32'(ob_gnt[0]), 32'(2'b01));

    // random traffic with occasional reset
    for (int c = 0; c < 10000; c++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++)
        for (int n = 0; n < 2; n++)
          if (!st_req[k][n] || m_gnt[k][n]) rand_port(k, n);
    end

    tick();
    rst = 1'b0;
    idle_all();
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
